// File: rtl/seq_detect_ctrl_if.sv
// Bus bundle for seq_detect_ctrl: run configuration, start/abort, serial bit stream and status.
// The last_pos stamp only exists when MATCH_STAMP_EN is defined.
interface seq_detect_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
);
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic [TMO_W-1:0]   cfg_timeout;
    logic               start;
    logic               abort;
    logic               x_valid;
    logic               x;
    logic               busy;
    logic               hit;
    logic [CNT_W-1:0]   match_cnt;
    logic               done;
    logic               timed_out;
    logic               cfg_err;
`ifdef MATCH_STAMP_EN
    logic [15:0]        last_pos;
`endif

    // Handshake: start is a one-cycle request sampled only in IDLE; x is consumed on every
    // rising edge where x_valid=1 while busy, with no backpressure. hit/done/cfg_err are pulses.
    modport master (
        output cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        output start, abort, x_valid, x,
        input  busy, hit, match_cnt, done, timed_out, cfg_err
`ifdef MATCH_STAMP_EN
        , input last_pos
`endif
    );

    modport slave (
        input  cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
        input  start, abort, x_valid, x,
        output busy, hit, match_cnt, done, timed_out, cfg_err
`ifdef MATCH_STAMP_EN
        , output last_pos
`endif
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector with a session controller (IDLE/RUN/DONE).
// Optional feature macro: MATCH_STAMP_EN adds the last_pos bit-index stamp of the latest hit.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [3:0]         len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [TMO_W-1:0]   lim_q, lim_d;
    logic [MAX_LEN-2:0] win_q, win_d;
    logic [3:0]         fill_q, fill_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit_q, hit_d;
    logic               tout_q, tout_d;
    logic               err_q, err_d;
`ifdef MATCH_STAMP_EN
    logic [15:0]        pos_q, pos_d;
    logic [15:0]        last_q, last_d;
`endif

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [3:0]         fill_inc;
    logic [TMO_W-1:0]   tmo_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               match_now;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            lim_q   <= '0;
            win_q   <= '0;
            fill_q  <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            tout_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MATCH_STAMP_EN
            pos_q   <= '0;
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            lim_q   <= lim_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            tout_q  <= tout_d;
            err_q   <= err_d;
`ifdef MATCH_STAMP_EN
            pos_q   <= pos_d;
            last_q  <= last_d;
`endif
        end
    end

    // The compared window is the stored history plus the bit arriving this cycle.
    always_comb begin
        window   = {win_q, bus.x};
        fill_inc = (fill_q == MAX_LEN_L) ? fill_q : fill_q + 4'd1;
        tmo_inc  = tmo_q + TMO_W'(1);
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        match_now = bus.x_valid && (fill_inc >= len_q) && ((window & mask) == (pat_q & mask));
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        lim_d   = lim_q;
        win_d   = win_q;
        fill_d  = fill_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        tout_d  = tout_q;
        err_d   = 1'b0;
`ifdef MATCH_STAMP_EN
        pos_d   = pos_q;
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_len == 4'd0 || bus.cfg_len > MAX_LEN_L) begin
                        err_d = 1'b1;
                    end else begin
                        pat_d   = bus.cfg_pattern;
                        len_d   = bus.cfg_len;
                        ovl_d   = bus.cfg_overlap;
                        tgt_d   = bus.cfg_target;
                        lim_d   = bus.cfg_timeout;
                        win_d   = '0;
                        fill_d  = '0;
                        tmo_d   = '0;
                        cnt_d   = '0;
                        tout_d  = 1'b0;
`ifdef MATCH_STAMP_EN
                        pos_d   = '0;
                        last_d  = '0;
`endif
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_inc;
                    if (bus.x_valid) begin
                        win_d  = window[MAX_LEN-2:0];
                        fill_d = fill_inc;
`ifdef MATCH_STAMP_EN
                        pos_d  = pos_q + 16'd1;
`endif
                    end
                    if (match_now) begin
                        hit_d = 1'b1;
                        cnt_d = cnt_inc;
                        tmo_d = '0;
                        if (!ovl_q) fill_d = '0;
`ifdef MATCH_STAMP_EN
                        last_d = pos_q;
`endif
                        if (tgt_q != '0 && cnt_inc == tgt_q) state_d = DONE;
                    end else if (lim_q != '0 && tmo_inc == lim_q) begin
                        tout_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.hit       = hit_q;
    assign bus.match_cnt = cnt_q;
    assign bus.timed_out = tout_q;
    assign bus.cfg_err   = err_q;
`ifdef MATCH_STAMP_EN
    assign bus.last_pos  = last_q;
`endif
endmodule
